cart_flash_bridge: RTL and testbench

//  Parametrised cartridge bridge between the gameboy core bus (a/din/dout/rd/wr) and the
//  16-bit parallel NOR flash holding the ROM image. Replaces the fixed combinational

---
 rtl/cart_pkg.sv | 27 ++
 rtl/mbc1_regs.sv | 64 ++++++
 rtl/cart_flash_bridge.sv | 140 ++++++++++++++
 tb/tb_cart_flash_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge flash bridge and its MBC1 register block.
package cart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_CAPT = 2'd3
  } state_t;

  localparam int MBC_NONE = 0;
  localparam int MBC1     = 1;

  // MBC1 register selected by a[14:13] of a write into 0x0000-0x7FFF
  localparam logic [1:0] REG_RAMEN  = 2'b00;
  localparam logic [1:0] REG_BANKLO = 2'b01;
  localparam logic [1:0] REG_BANKHI = 2'b10;
  localparam logic [1:0] REG_MODE   = 2'b11;

  localparam int BANK_SIZE_LOG2 = 14;

  // MBC1 never maps bank 0 through the low bank register
  function automatic logic [4:0] fix_bank_lo(input logic [4:0] v);
    return (v == 5'd0) ? 5'd1 : v;
  endfunction

endpackage

// File: rtl/mbc1_regs.sv
// MBC1 control registers: write decode, bank/mode/ram-enable state and the
// effective ROM bank for the address currently on the bus.
module mbc1_regs
  import cart_pkg::*;
#(
  parameter int MBC_MODE      = MBC1,
  parameter int ROM_BANK_BITS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wdata,
  input  logic       rd_a14,
  output logic [7:0] bank_sel,
  output logic [7:0] rom_bank,
  output logic       ram_en
);

  localparam logic [7:0] BANK_MASK = 8'((1 << ROM_BANK_BITS) - 1);

  generate
    if (MBC_MODE == MBC_NONE) begin : g_flat
      logic unused_flat;
      assign unused_flat = ^{clk, rst, wr_en, wr_sel, wdata};
      assign bank_sel    = {7'd0, rd_a14};
      assign rom_bank    = 8'd1;
      assign ram_en      = 1'b0;
    end else begin : g_mbc1
      logic [4:0] bank_lo_reg;
      logic [1:0] bank_hi_reg;
      logic       mode_reg;
      logic       ram_en_reg;
      logic [7:0] hi_bank;
      logic [7:0] lo_bank;
      logic       unused_wdata;

      always_ff @(posedge clk) begin
        if (rst) begin
          bank_lo_reg <= 5'd1;
          bank_hi_reg <= 2'd0;
          mode_reg    <= 1'b0;
          ram_en_reg  <= 1'b0;
        end else if (wr_en) begin
          case (wr_sel)
            REG_RAMEN:  ram_en_reg  <= (wdata[3:0] == 4'hA);
            REG_BANKLO: bank_lo_reg <= fix_bank_lo(wdata[4:0]);
            REG_BANKHI: bank_hi_reg <= wdata[1:0];
            REG_MODE:   mode_reg    <= wdata[0];
          endcase
        end
      end

      // Mode 1 lets bank_hi also page the 0x0000-0x3FFF window
      assign hi_bank      = {1'b0, bank_hi_reg, bank_lo_reg} & BANK_MASK;
      assign lo_bank      = mode_reg ? ({1'b0, bank_hi_reg, 5'd0} & BANK_MASK) : 8'd0;
      assign bank_sel     = rd_a14 ? hi_bank : lo_bank;
      assign rom_bank     = hi_bank;
      assign ram_en       = ram_en_reg;
      assign unused_wdata = ^wdata[7:5];
    end
  endgenerate

endmodule

// File: rtl/cart_flash_bridge.sv
// Game Boy cartridge bus to 16-bit NOR flash bridge: wait-stated read sequencer
// with optional MBC1 bank switching.
module cart_flash_bridge
  import cart_pkg::*;
#(
  parameter int FLASH_AW      = 24,
  parameter int ROM_BASE      = 0,
  parameter int WAIT_CYCLES   = 3,
  parameter int MBC_MODE      = MBC1,
  parameter int ROM_BANK_BITS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         gb_a,
  input  logic [7:0]          gb_wdata,
  input  logic                gb_rd,
  input  logic                gb_wr,
  output logic [7:0]          gb_rdata,
  output logic                gb_ready,
  output logic [FLASH_AW-1:0] flash_a,
  input  logic [15:0]         flash_d,
  output logic                flash_ce_b,
  output logic                flash_oe_b,
  output logic                flash_adv_b,
  output logic [7:0]          rom_bank,
  output logic                ram_en
);

  localparam int PAGE_SHIFT = BANK_SIZE_LOG2 - 1;

  state_t              state_reg, state_next;
  logic [3:0]          wait_cnt_reg;
  logic [15:0]         gb_a_q_reg;
  logic [15:0]         last_a_reg;
  logic                rd_q_reg;
  logic [15:0]         flash_q_reg;
  logic [7:0]          gb_rdata_reg;
  logic [FLASH_AW-1:0] flash_a_reg;
  logic [FLASH_AW-1:0] word_addr;
  logic [7:0]          bank_sel;
  logic                start;
  logic                wait_done;
  logic                mbc_wr;

  assign mbc_wr = gb_wr & ~gb_a[15];

  mbc1_regs #(
    .MBC_MODE      (MBC_MODE),
    .ROM_BANK_BITS (ROM_BANK_BITS)
  ) u_mbc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (mbc_wr),
    .wr_sel   (gb_a[14:13]),
    .wdata    (gb_wdata),
    .rd_a14   (gb_a[14]),
    .bank_sel (bank_sel),
    .rom_bank (rom_bank),
    .ram_en   (ram_en)
  );

  // A held read of the same address must not re-fetch; a new address does
  assign start = (state_reg == ST_IDLE) & gb_rd & ~gb_wr & ~gb_a[15]
               & (~rd_q_reg | (gb_a != last_a_reg));

  // ROM_BASE is even, so the byte offset halves cleanly into a word offset
  assign word_addr = FLASH_AW'(ROM_BASE / 2)
                   + (FLASH_AW'(bank_sel) << PAGE_SHIFT)
                   + FLASH_AW'(gb_a[13:1]);

  assign wait_done = (state_reg == ST_WAIT) && (wait_cnt_reg == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_ADDR;
      ST_ADDR: state_next = ST_WAIT;
      ST_WAIT: if (wait_done) state_next = ST_CAPT;
      ST_CAPT: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    flash_ce_b  = 1'b1;
    flash_oe_b  = 1'b1;
    flash_adv_b = 1'b1;
    gb_ready    = (state_reg == ST_IDLE) & ~start;
    case (state_reg)
      ST_ADDR: begin
        flash_ce_b  = 1'b0;
        flash_adv_b = 1'b0;
      end
      ST_WAIT: begin
        flash_ce_b = 1'b0;
        flash_oe_b = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= 4'd0;
      gb_a_q_reg   <= 16'd0;
      last_a_reg   <= 16'd0;
      rd_q_reg     <= 1'b0;
      flash_q_reg  <= 16'd0;
      gb_rdata_reg <= 8'hFF;
      flash_a_reg  <= '0;
    end else begin
      rd_q_reg     <= gb_rd;
      wait_cnt_reg <= (state_reg == ST_WAIT) ? wait_cnt_reg + 4'd1 : 4'd0;
      if (start) begin
        flash_a_reg <= word_addr;
        gb_a_q_reg  <= gb_a;
      end
      // Sample the bus while oe_b is still low; CAPT only steers the byte lane
      if (wait_done) begin
        flash_q_reg <= flash_d;
      end
      if (state_reg == ST_CAPT) begin
        gb_rdata_reg <= gb_a_q_reg[0] ? flash_q_reg[15:8] : flash_q_reg[7:0];
        last_a_reg   <= gb_a_q_reg;
      end
    end
  end

  assign gb_rdata = gb_rdata_reg;
  assign flash_a  = flash_a_reg;

endmodule

// File: tb/tb_cart_flash_bridge.sv
// Directed bench for cart_flash_bridge: a flat (no MBC) and an MBC1 instance share the
// CPU bus and are checked every cycle against a transaction-timeline model.
module tb_cart_flash_bridge;

  localparam int W  = 3;
  localparam int BB = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gb_a;
  logic [7:0]  gb_wdata;
  logic        gb_rd;
  logic        gb_wr;

  logic [7:0]  dut_rdata [2];
  logic        dut_ready [2];
  logic [23:0] dut_fa    [2];
  logic [15:0] fd        [2];
  logic        dut_ce_b  [2];
  logic        dut_oe_b  [2];
  logic        dut_adv_b [2];
  logic [7:0]  dut_bank  [2];
  logic        dut_ram   [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Flash image: word 0x80 is pinned, everything else is a scrambled pattern
  function automatic logic [15:0] flash_word(input logic [23:0] wa);
    logic [31:0] t;
    if (wa == 24'h80) return 16'h00C3;
    t = {8'h0, wa} * 32'h0000_9E37 + 32'h1234;
    return t[23:8];
  endfunction

  assign fd[0] = dut_oe_b[0] ? 16'hDEAD : flash_word(dut_fa[0]);
  assign fd[1] = dut_oe_b[1] ? 16'hDEAD : flash_word(dut_fa[1]);

  cart_flash_bridge #(.FLASH_AW(24), .ROM_BASE(0), .WAIT_CYCLES(W), .MBC_MODE(0), .ROM_BANK_BITS(BB)) dut_flat (
    .clk(clk), .rst(rst), .gb_a(gb_a), .gb_wdata(gb_wdata), .gb_rd(gb_rd), .gb_wr(gb_wr),
    .gb_rdata(dut_rdata[0]), .gb_ready(dut_ready[0]), .flash_a(dut_fa[0]), .flash_d(fd[0]),
    .flash_ce_b(dut_ce_b[0]), .flash_oe_b(dut_oe_b[0]), .flash_adv_b(dut_adv_b[0]),
    .rom_bank(dut_bank[0]), .ram_en(dut_ram[0])
  );

  cart_flash_bridge #(.FLASH_AW(24), .ROM_BASE(0), .WAIT_CYCLES(W), .MBC_MODE(1), .ROM_BANK_BITS(BB)) dut_mbc (
    .clk(clk), .rst(rst), .gb_a(gb_a), .gb_wdata(gb_wdata), .gb_rd(gb_rd), .gb_wr(gb_wr),
    .gb_rdata(dut_rdata[1]), .gb_ready(dut_ready[1]), .flash_a(dut_fa[1]), .flash_d(fd[1]),
    .flash_ce_b(dut_ce_b[1]), .flash_oe_b(dut_oe_b[1]), .flash_adv_b(dut_adv_b[1]),
    .rom_bank(dut_bank[1]), .ram_en(dut_ram[1])
  );

  // ---------------- model: index 0 = flat, index 1 = MBC1 ----------------
  int          cyc = 0;
  bit          model_on = 0;
  int          acc      [2];
  bit          acc_v    [2];
  logic [15:0] addr_q   [2];
  int          exp_fa   [2];
  logic [7:0]  exp_rdata[2];
  logic [15:0] last_addr[2];
  bit          prev_rd  [2];
  int          bank_lo  [2];
  int          bank_hi  [2];
  bit          mode     [2];
  bit          ram_en_m [2];

  function automatic bit in_flight(input int i, input int c);
    return acc_v[i] && (c - acc[i] >= 0) && (c - acc[i] <= W + 1);
  endfunction

  function automatic bit req_at(input int i, input int c);
    return gb_rd && !gb_wr && !gb_a[15] && !in_flight(i, c)
        && (!prev_rd[i] || gb_a != last_addr[i]);
  endfunction

  function automatic int hi_bank(input int i);
    return (bank_hi[i] * 32 + bank_lo[i]) & ((1 << BB) - 1);
  endfunction

  function automatic int bank_for(input int i, input logic [15:0] a);
    if (i == 0) return int'(a[14]);
    if (a[14]) return hi_bank(i);
    return mode[i] ? ((bank_hi[i] * 32) & ((1 << BB) - 1)) : 0;
  endfunction

  function automatic int word_of(input int bank, input logic [15:0] a);
    return ((0 + bank * 16384 + int'(a[13:0])) / 2) & 32'h00FF_FFFF;
  endfunction

  always @(posedge clk) begin
    bit req [2];
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      if (rst) begin
        acc_v[i] = 0; exp_fa[i] = 0; exp_rdata[i] = 8'hFF; last_addr[i] = 16'h0;
        prev_rd[i] = 0; bank_lo[i] = 1; bank_hi[i] = 0; mode[i] = 0; ram_en_m[i] = 0;
      end else begin
        if (acc_v[i] && cyc - acc[i] == W + 1) begin
          w = flash_word(24'(exp_fa[i]));
          exp_rdata[i] = addr_q[i][0] ? w[15:8] : w[7:0];
          last_addr[i] = addr_q[i];
        end
        if (req_at(i, cyc)) begin
          req[i]    = 1'b1;
          addr_q[i] = gb_a;
          exp_fa[i] = word_of(bank_for(i, gb_a), gb_a);
        end
        if (i == 1 && gb_wr && !gb_a[15]) begin
          case (gb_a[14:13])
            2'b00: ram_en_m[i] = (gb_wdata[3:0] == 4'hA);
            2'b01: bank_lo[i]  = (gb_wdata[4:0] == 5'd0) ? 1 : int'(gb_wdata[4:0]);
            2'b10: bank_hi[i]  = int'(gb_wdata[1:0]);
            default: mode[i]   = gb_wdata[0];
          endcase
        end
        prev_rd[i] = gb_rd;
      end
    end
    if (rst) model_on = 1;
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (req[i]) begin
        acc[i] = cyc; acc_v[i] = 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    int p;
    bit live;
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        p    = cyc - acc[i];
        live = acc_v[i] && p >= 0;
        chk($sformatf("c%0d_i%0d_ready", cyc, i), dut_ready[i], !(live && p <= W + 1) && !req_at(i, cyc));
        chk($sformatf("c%0d_i%0d_adv_b", cyc, i), dut_adv_b[i], !(live && p == 0));
        chk($sformatf("c%0d_i%0d_ce_b", cyc, i), dut_ce_b[i], !(live && p <= W));
        chk($sformatf("c%0d_i%0d_oe_b", cyc, i), dut_oe_b[i], !(live && p >= 1 && p <= W));
        chk($sformatf("c%0d_i%0d_flash_a", cyc, i), dut_fa[i], exp_fa[i]);
        chk($sformatf("c%0d_i%0d_rdata", cyc, i), dut_rdata[i], exp_rdata[i]);
        chk($sformatf("c%0d_i%0d_rom_bank", cyc, i), dut_bank[i], (i == 0) ? 1 : hi_bank(i));
        chk($sformatf("c%0d_i%0d_ram_en", cyc, i), dut_ram[i], (i == 0) ? 0 : ram_en_m[i]);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic rd_txn(input logic [15:0] a);
    @(posedge clk); #1; gb_rd = 1'b1; gb_a = a;
    repeat (8) @(negedge clk);
    @(posedge clk); #1; gb_rd = 1'b0;
    $display("read  a=%04h -> flat rdata=%02h fa=%06h | mbc rdata=%02h fa=%06h bank=%02h",
             a, dut_rdata[0], dut_fa[0], dut_rdata[1], dut_fa[1], dut_bank[1]);
  endtask

  task automatic wr_txn(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1; gb_wr = 1'b1; gb_a = a; gb_wdata = d;
    @(posedge clk); #1; gb_wr = 1'b0;
    $display("write a=%04h d=%02h -> mbc bank=%02h ram_en=%0b", a, d, dut_bank[1], dut_ram[1]);
  endtask

  initial begin
    int low0, low1, adv0, adv1, ce1;
    rst = 1'b1; gb_a = 16'h0; gb_wdata = 8'h0; gb_rd = 1'b0; gb_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", dut_rdata[1], 8'hFF);
    chk("reset_ready", dut_ready[1], 1);
    chk("reset_ce_b", dut_ce_b[1], 1);
    chk("reset_flash_a", dut_fa[1], 0);
    chk("reset_rom_bank", dut_bank[1], 1);

    // 1: first fetch of 0x0100 (word 0x80, low lane)
    @(posedge clk); #1; gb_rd = 1'b1; gb_a = 16'h0100;
    @(negedge clk);
    low0 = 0; low1 = 0;
    repeat (8) begin
      @(negedge clk);
      if (!dut_ready[0]) low0++;
      if (!dut_ready[1]) low1++;
    end
    chk("t1_busy_cycles_flat", low0, 5);
    chk("t1_busy_cycles_mbc", low1, 5);
    chk("t1_rdata_flat", dut_rdata[0], 8'hC3);
    chk("t1_flash_a_flat", dut_fa[0], 24'h80);
    $display("read  a=0100 -> flat rdata=%02h busy=%0d", dut_rdata[0], low0);

    // 2: odd byte of the same word, then hold rd for many cycles
    @(posedge clk); #1; gb_a = 16'h0101;
    adv0 = 0; adv1 = 0;
    repeat (14) begin
      @(negedge clk);
      if (!dut_adv_b[0]) adv0++;
      if (!dut_adv_b[1]) adv1++;
    end
    chk("t2_rdata_flat", dut_rdata[0], 8'h00);
    chk("t2_adv_pulses_flat", adv0, 1);
    chk("t2_adv_pulses_mbc", adv1, 1);
    $display("read  a=0101 held -> flat rdata=%02h adv pulses=%0d", dut_rdata[0], adv0);
    @(posedge clk); #1; gb_rd = 1'b0;

    // 3: writing 0 to bank_lo still selects bank 1
    wr_txn(16'h2000, 8'h00);
    rd_txn(16'h4000);
    chk("t3_flash_a_mbc", dut_fa[1], 24'h002000);
    chk("t3_rom_bank", dut_bank[1], 8'h01);

    // 4: bank 0x25 via bank_hi, then RAM enable and mode 1
    wr_txn(16'h2000, 8'h05);
    wr_txn(16'h4000, 8'h01);
    rd_txn(16'h4002);
    chk("t4_flash_a_mbc", dut_fa[1], 24'h04A001);
    chk("t4_flash_a_flat", dut_fa[0], 24'h002001);
    chk("t4_rom_bank", dut_bank[1], 8'h25);
    wr_txn(16'h0000, 8'h1A);
    chk("t4_ram_en_mbc", dut_ram[1], 1);
    chk("t4_ram_en_flat", dut_ram[0], 0);
    wr_txn(16'h6000, 8'h01);
    rd_txn(16'h0000);
    chk("t4_mode1_flash_a", dut_fa[1], 24'h040000);
    wr_txn(16'h6000, 8'h00);

    // 5: reset in the middle of the wait phase
    @(posedge clk); #1; gb_rd = 1'b1; gb_a = 16'h4000;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1; gb_rd = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t5_ce_b", dut_ce_b[1], 1);
    chk("t5_oe_b", dut_oe_b[1], 1);
    chk("t5_ready", dut_ready[1], 1);
    chk("t5_rdata", dut_rdata[1], 8'hFF);
    chk("t5_rom_bank", dut_bank[1], 8'h01);
    $display("reset mid-read -> ce_b=%0b oe_b=%0b rdata=%02h", dut_ce_b[1], dut_oe_b[1], dut_rdata[1]);

    // 6: bank write while a bank-1 read is in flight
    @(posedge clk); #1; gb_rd = 1'b1; gb_a = 16'h4000;
    @(posedge clk); #1;
    @(posedge clk); #1; gb_wr = 1'b1; gb_a = 16'h2000; gb_wdata = 8'h03;
    @(posedge clk); #1; gb_wr = 1'b0; gb_a = 16'h4000;
    repeat (6) @(negedge clk);
    chk("t6_inflight_flash_a", dut_fa[1], 24'h002000);
    chk("t6_bank_after_write", dut_bank[1], 8'h03);
    @(posedge clk); #1; gb_rd = 1'b0;
    rd_txn(16'h4000);
    chk("t6_next_flash_a", dut_fa[1], 24'h006000);
    chk("t6_flat_flash_a", dut_fa[0], 24'h002000);

    // rd and wr together while idle: write lands, no fetch
    @(posedge clk); #1; gb_rd = 1'b1; gb_wr = 1'b1; gb_a = 16'h2000; gb_wdata = 8'h02;
    @(negedge clk);
    chk("rdwr_ready", dut_ready[1], 1);
    @(posedge clk); #1; gb_rd = 1'b0; gb_wr = 1'b0;
    chk("rdwr_rom_bank", dut_bank[1], 8'h02);
    $display("rd+wr a=2000 d=02 -> bank=%02h", dut_bank[1]);

    // high-half reads never touch flash
    @(posedge clk); #1; gb_rd = 1'b1; gb_a = 16'hC000;
    low1 = 0; ce1 = 0;
    repeat (5) begin
      @(negedge clk);
      if (!dut_ready[1]) low1++;
      if (!dut_ce_b[1]) ce1++;
    end
    chk("hi_read_ready_low", low1, 0);
    chk("hi_read_ce_low", ce1, 0);
    @(posedge clk); #1; gb_rd = 1'b0;
    $display("read  a=C000 -> ready low cycles=%0d ce low cycles=%0d", low1, ce1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
